// File: rtl/sw_debounce.sv
// sw_debounce
//   Conditions raw board slide-switch pins before they reach the GPIO switch
//   read port. Each bit is synchronised into clk by two flops, then
//   debounced against a shared sample tick from a free-running prescaler.
//   A bit accepts a new level only after STABLE_TICKS consecutive ticks in
//   which the synchronised input differs from the current debounced level.
//   Any tick-independent return to the debounced level restarts the count.
//   When a debounced level changes, the bit raises a registered one-cycle
//   rise or fall pulse.
//
// Ports
//   clk           in   1      system clock
//   rst_n         in   1      asynchronous active-low reset
//   pin_sw_raw_i  in   WIDTH  raw asynchronous switch pins
//   sw_o          out  WIDTH  debounced switch levels
//   sw_rise_o     out  WIDTH  one-cycle pulse per bit on debounced 0->1
//   sw_fall_o     out  WIDTH  one-cycle pulse per bit on debounced 1->0
//
// Parameters
//   WIDTH         number of switch bits
//   TICK_DIV      clk cycles per sample tick (>= 2)
//   STABLE_TICKS  consecutive mismatching ticks needed to accept a level (>= 1)

module sw_debounce #(
    parameter int WIDTH        = 16,
    parameter int TICK_DIV     = 50000,
    parameter int STABLE_TICKS = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] pin_sw_raw_i,
    output logic [WIDTH-1:0] sw_o,
    output logic [WIDTH-1:0] sw_rise_o,
    output logic [WIDTH-1:0] sw_fall_o
);

    localparam int DIV_W = $clog2(TICK_DIV);
    localparam int CNT_W = $clog2(STABLE_TICKS + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

    // Two-flop synchroniser; sync2_q is the only view of the raw pins.
    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;

    // Free-running prescaler, 0..TICK_DIV-1.
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             tick;

    // Per-bit qualification counters and debounced state.
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] sw_q;
    logic [WIDTH-1:0] sw_d;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] rise_d;
    logic [WIDTH-1:0] fall_q;
    logic [WIDTH-1:0] fall_d;

    assign tick = (div_q == DIV_LAST);

    always_comb begin
        div_d = tick ? '0 : div_q + DIV_W'(1);
    end

    // Counter only advances on a tick while the input disagrees with the
    // debounced level; any agreement clears it immediately, so a glitch
    // shorter than STABLE_TICKS ticks never reaches acceptance. The counter
    // tops out at STABLE_TICKS-1 because that is the acceptance point.
    always_comb begin
        sw_d   = sw_q;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == sw_q[i]) begin
                cnt_d[i] = '0;
            end else if (tick) begin
                if (cnt_q[i] == CNT_LAST) begin
                    sw_d[i]   = sync2_q[i];
                    cnt_d[i]  = '0;
                    // Pulses register alongside sw_q so they line up with the
                    // first cycle the new level is visible.
                    rise_d[i] = sync2_q[i];
                    fall_d[i] = ~sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            div_q   <= '0;
            sw_q    <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= pin_sw_raw_i;
            sync2_q <= sync1_q;
            div_q   <= div_d;
            sw_q    <= sw_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign sw_o      = sw_q;
    assign sw_rise_o = rise_q;
    assign sw_fall_o = fall_q;

endmodule

// File: tb/tb_sw_debounce.sv
// tb_sw_debounce
//   Directed bench for sw_debounce with TICK_DIV=4, STABLE_TICKS=3,
//   WIDTH=16. Stimulus pushes the expected pulse event (rise/fall mask,
//   debounced level, latency window) into a queue; a monitor pops and
//   compares whenever the DUT shows any rise or fall pulse.

module tb_sw_debounce;

  localparam int W  = 16;
  localparam int TD = 4;
  localparam int ST = 3;

  localparam int LAT_MIN = 2 + (ST - 1) * TD + 1;  // 11
  localparam int LAT_MAX = 2 + ST * TD;            // 14

  logic         clk;
  logic         rst_n;
  logic [W-1:0] pin_sw_raw_i;
  logic [W-1:0] sw_o;
  logic [W-1:0] sw_rise_o;
  logic [W-1:0] sw_fall_o;

  int checks;
  int errors;
  int cyc;

  typedef struct {
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic [W-1:0] level;
    int           t0;
    int           tmin;
    int           tmax;
  } exp_t;

  exp_t exp_q[$];

  sw_debounce #(
    .WIDTH(W),
    .TICK_DIV(TD),
    .STABLE_TICKS(ST)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pin_sw_raw_i(pin_sw_raw_i),
    .sw_o(sw_o),
    .sw_rise_o(sw_rise_o),
    .sw_fall_o(sw_fall_o)
  );

  // clock / cycle counter
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input logic [W-1:0] rise, input logic [W-1:0] fall,
                          input logic [W-1:0] level, input int tmin, input int tmax);
    exp_t e;
    e.rise  = rise;
    e.fall  = fall;
    e.level = level;
    e.t0    = cyc;
    e.tmin  = tmin;
    e.tmax  = tmax;
    exp_q.push_back(e);
  endtask

  // driver tasks
  task automatic drive(input logic [W-1:0] v);
    @(negedge clk);
    pin_sw_raw_i = v;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait for the scoreboard to drain, then a few quiet cycles so a stretched
  // or duplicate pulse is seen by the monitor as unexpected.
  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d events still pending, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    wait_cycles(4);
  endtask

  // monitor
  initial begin
    exp_t e;
    int   lat;
    forever begin
      @(negedge clk);
      if ((sw_rise_o | sw_fall_o) != '0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: rise %h fall %h sw %h, expected no pulse (cycle %0d)",
                   sw_rise_o, sw_fall_o, sw_o, cyc);
        end else begin
          e = exp_q.pop_front();
          check("rise", sw_rise_o, e.rise);
          check("fall", sw_fall_o, e.fall);
          check("level", sw_o, e.level);
          lat = cyc - e.t0;
          checks++;
          if (lat < e.tmin || lat > e.tmax) begin
            errors++;
            $display("FAIL latency: got %0d cycles expected %0d..%0d", lat, e.tmin, e.tmax);
          end
        end
      end
    end
  end

  // stimulus
  initial begin
    logic [W-1:0] raw;

    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    pin_sw_raw_i = 16'hFFFF;

    // 1: reset with all pins high
    wait_cycles(3);
    check("reset_sw", sw_o, 16'h0000);
    check("reset_rise", sw_rise_o, 16'h0000);
    check("reset_fall", sw_fall_o, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    push_exp(16'hFFFF, 16'h0000, 16'hFFFF, 2, LAT_MAX);
    drain("t1_rise");

    // all pins low again: full-width fall
    drive(16'h0000);
    push_exp(16'h0000, 16'hFFFF, 16'h0000, LAT_MIN, LAT_MAX);
    drain("all_fall");

    // 2: clean step on bit 3
    drive(16'h0008);
    push_exp(16'h0008, 16'h0000, 16'h0008, LAT_MIN, LAT_MAX);
    drain("t2_step");

    // 3: bounce on bit 0, 13 toggles every 3 cycles, ends high
    raw = 16'h0008;
    for (int k = 0; k < 13; k++) begin
      raw[0] = ~raw[0];
      drive(raw);
      if (k != 12) wait_cycles(2);
    end
    push_exp(16'h0001, 16'h0000, 16'h0009, LAT_MIN, LAT_MAX);
    drain("t3_bounce");

    // 4: 6-cycle glitch on bit 5
    drive(16'h0029);
    wait_cycles(5);
    drive(16'h0009);
    wait_cycles(20);
    check("t4_glitch_sw", sw_o, 16'h0009);

    // 5: bits 1 and 9 raised together, then dropped together
    drive(16'h020B);
    push_exp(16'h0202, 16'h0000, 16'h020B, LAT_MIN, LAT_MAX);
    drain("t5_rise");
    drive(16'h0009);
    push_exp(16'h0000, 16'h0202, 16'h0009, LAT_MIN, LAT_MAX);
    drain("t5_fall");

    // 6: one-cycle reset while bit 7 is qualifying
    drive(16'h0089);
    wait_cycles(7);
    check("t6_pre_reset_sw", sw_o, 16'h0009);
    rst_n = 1'b0;
    #1;
    check("t6_in_reset_sw", sw_o, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    push_exp(16'h0089, 16'h0000, 16'h0089, LAT_MIN, LAT_MAX);
    wait_cycles(3);
    check("t6_after_reset_sw", sw_o, 16'h0000);
    drain("t6_requal");
    check("t6_final_sw", sw_o, 16'h0089);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
